farrow_sched: RTL and testbench
===============================

FARROW_SCHED -- requirements
Module: farrow_sched

Interface
REQ-001 Parameter FILL, default 4: number of input samples that must enter the Farrow tap buffer before outputs are allowed.
REQ-002 Parameter DEF_IN_DIV, default 3: in_div value loaded at reset.
REQ-003 Parameter DEF_OUT_DIV, default 4: out_div value loaded at reset.
REQ-004 Parameter DEF_DELTA, default 85: delta value loaded at reset.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-007 Port reset  input  1  synchronous active-high reset.
REQ-008 Port start  input  1  level; sampled in IDLE only, begins a run.
REQ-009 Port stop  input  1  level; aborts the run from any non-IDLE state.
REQ-010 Port cfg_we  input  1  one-cycle config write strobe.
REQ-011 Port cfg_in_div  input  4  clocks per input sample.
REQ-012 Port cfg_out_div  input  4  clocks per output sample.
REQ-013 Port cfg_delta  input  8  fractional-delay increment, scaled by 256.
REQ-014 Port ena_in  output  1  tap-line shift enable to the Farrow datapath.
REQ-015 Port ena_out  output  1  sample-and-compute enable to the Farrow datapath.
REQ-016 Port d_out  output  9  current fractional delay, range 0..255, MSB always 0.
REQ-017 Port wrap  output  1  delay accumulator overflows on this ena_out.
REQ-018 Port primed  output  1  high in RUN.
REQ-019 Port busy  output  1  high in FILL or RUN.
REQ-020 Port cfg_err  output  1  one-cycle pulse when a config write is rejected.
REQ-021 Port state_o  output  2  state encoding: IDLE=0, FILL=1, RUN=2.

Function
REQ-022 All outputs SHALL be decoded from registers only; there is no combinational path from any input to any output.
REQ-023 FSM: IDLE -> FILL when start=1; FILL -> RUN on the FILL-th ena_in; FILL or RUN -> IDLE when stop=1.
REQ-024 When stop and start are high in the same cycle, stop SHALL win.
REQ-025 On IDLE -> FILL, in_cnt, out_cnt, fill_cnt and d SHALL all be cleared to 0.
REQ-026 In FILL and RUN, in_cnt counts 0..in_div-1 cyclically; ena_in=1 exactly while in_cnt==in_div-1.
REQ-027 With in_div=1, ena_in SHALL be high on every FILL/RUN cycle.
REQ-028 out_cnt SHALL be held at 0 outside RUN; in RUN it counts 0..out_div-1 from the first RUN cycle.
REQ-029 ena_out=1 exactly while state is RUN and out_cnt==out_div-1.
REQ-030 d_out SHALL hold the delay used by the current ena_out.
REQ-031 On each ena_out edge, d <= (d+delta) mod 256, with wrap = (d+delta >= 256) during that ena_out cycle; otherwise wrap=0.
REQ-032 d SHALL change only on ena_out.
REQ-033 ena_in and ena_out may be asserted in the same cycle; both act independently.
REQ-034 cfg_we in IDLE with nonzero in_div and out_div SHALL load all three config fields at the edge.
REQ-035 cfg_we outside IDLE, or with either div = 0, SHALL leave config unchanged and pulse cfg_err for one cycle.
REQ-036 Entering IDLE via stop SHALL force ena_in=ena_out=wrap=0 from the next cycle; d holds its value until the next start.

Reset
REQ-037 reset, sampled at a clock edge, SHALL override all other inputs.
REQ-038 After reset: state=IDLE; in_cnt=out_cnt=fill_cnt=0; d=0; config = DEF_IN_DIV/DEF_OUT_DIV/DEF_DELTA.
REQ-039 After reset: ena_in=ena_out=wrap=primed=busy=cfg_err=0.
REQ-040 Reset mid-run SHALL behave identically to reset from IDLE.

Structure
REQ-041 Package farrow_pkg SHALL hold the state encoding, D_W=9, DIV_W=4 and the default constants.
REQ-042 Sub-module farrow_divcnt SHALL implement the mod-N counter with synchronous clear, enable and terminal-count flag.
REQ-043 farrow_divcnt SHALL be instantiated twice: once for the input divider and once for the output divider.

Verification
REQ-044 Scenario 1 (nominal run): reset, then start=1 in cycle 0 -> ena_in in cycles 3,6,9,12; RUN and primed from cycle 13; ena_out in cycles 16,20,24,28 with d_out 0,85,170,255; wrap=1 only in cycle 28; d=84 afterwards.
REQ-045 Scenario 2 (config): cfg_we in IDLE with in_div=1,out_div=2,delta=128, then start -> ena_in every cycle from cycle 1; RUN from cycle 5; d_out 0,128,0,... with wrap on every second ena_out.
REQ-046 Scenario 3 (rejected writes): cfg_we during RUN -> cfg_err pulse, cadence unchanged; cfg_we in IDLE with out_div=0 -> cfg_err pulse, config unchanged.
REQ-047 Scenario 4 (stop mid-FILL): stop after 2 ena_in -> IDLE next cycle, enables 0; restart -> full 4-sample FILL again.
REQ-048 Scenario 5 (simultaneous/mid-run events): start and stop high together in IDLE -> stays IDLE; reset asserted in RUN -> all REQ-038/REQ-039 values next cycle.

Source files
------------

// File: rtl/farrow_pkg.sv
// Shared constants and state encoding for the Farrow interpolator scheduler.
// Both the scheduler top and its divider counters use these definitions.
package farrow_pkg;

    localparam int D_W     = 9;
    localparam int DIV_W   = 4;
    localparam int DELTA_W = 8;

    localparam int FILL_DEF    = 4;
    localparam int IN_DIV_DEF  = 3;
    localparam int OUT_DIV_DEF = 4;
    localparam int DELTA_DEF   = 85;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/farrow_divcnt.sv
// Mod-N clock divider counter with synchronous clear, enable and terminal-count flag.
// The terminal count compares against div-1, so a divide of 1 flags on every cycle.
module farrow_divcnt
    import farrow_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] div,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] last;

    always_comb begin
        last  = div - W'(1);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == last) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == last);

endmodule

// File: rtl/farrow_sched.sv
// Enable/delay scheduler for a Farrow fractional-delay resampler: fills the tap line,
// then issues output strobes with an accumulating fractional delay d (scaled by 256).
module farrow_sched
    import farrow_pkg::*;
#(
    parameter int FILL        = FILL_DEF,
    parameter int DEF_IN_DIV  = IN_DIV_DEF,
    parameter int DEF_OUT_DIV = OUT_DIV_DEF,
    parameter int DEF_DELTA   = DELTA_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               cfg_we,
    input  logic [DIV_W-1:0]   cfg_in_div,
    input  logic [DIV_W-1:0]   cfg_out_div,
    input  logic [DELTA_W-1:0] cfg_delta,
    output logic               ena_in,
    output logic               ena_out,
    output logic [D_W-1:0]     d_out,
    output logic               wrap,
    output logic               primed,
    output logic               busy,
    output logic               cfg_err,
    output logic [1:0]         state_o
);

    localparam int FC_W = $clog2(FILL + 1);
    localparam logic [FC_W-1:0] FILL_LAST = FC_W'(FILL - 1);

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   in_div_q, in_div_d;
    logic [DIV_W-1:0]   out_div_q, out_div_d;
    logic [DELTA_W-1:0] delta_q, delta_d;
    logic [DELTA_W-1:0] d_q, d_d;
    logic [FC_W-1:0]    fill_cnt_q, fill_cnt_d;
    logic               cfg_err_q, cfg_err_d;

    logic               in_tc, out_tc;
    logic               in_clr, out_clr;
    logic               in_en, out_en;
    logic               run_start;
    logic               cfg_ok;
    logic [DELTA_W:0]   acc_sum;

    // Carry out of the 8-bit delay accumulator is the wrap indication.
    function automatic logic [DELTA_W:0] acc_step(input logic [DELTA_W-1:0] d,
                                                  input logic [DELTA_W-1:0] inc);
        return {1'b0, d} + {1'b0, inc};
    endfunction

    assign busy    = (state_q != ST_IDLE);
    assign primed  = (state_q == ST_RUN);
    assign state_o = state_q;
    assign ena_in  = busy & in_tc;
    assign ena_out = primed & out_tc;
    assign acc_sum = acc_step(d_q, delta_q);
    assign wrap    = ena_out & acc_sum[DELTA_W];
    assign d_out   = {1'b0, d_q};
    assign cfg_err = cfg_err_q;

    // Counters sit at zero whenever their phase is inactive or about to end.
    assign in_en   = busy;
    assign in_clr  = (state_q == ST_IDLE) || (state_d == ST_IDLE);
    assign out_en  = primed;
    assign out_clr = (state_q != ST_RUN) || (state_d != ST_RUN);

    farrow_divcnt #(.W(DIV_W)) u_in_div (
        .clk   (clk),
        .reset (reset),
        .clr   (in_clr),
        .en    (in_en),
        .div   (in_div_q),
        .tc    (in_tc)
    );

    farrow_divcnt #(.W(DIV_W)) u_out_div (
        .clk   (clk),
        .reset (reset),
        .clr   (out_clr),
        .en    (out_en),
        .div   (out_div_q),
        .tc    (out_tc)
    );

    always_comb begin
        state_d   = state_q;
        run_start = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d   = ST_FILL;
                    run_start = 1'b1;
                end
            end
            ST_FILL: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (ena_in && (fill_cnt_q == FILL_LAST)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fill_cnt_d = fill_cnt_q;
        d_d        = d_q;
        if (run_start) begin
            fill_cnt_d = '0;
            d_d        = '0;
        end else begin
            if ((state_q == ST_FILL) && ena_in) begin
                fill_cnt_d = fill_cnt_q + FC_W'(1);
            end
            if (ena_out) begin
                d_d = acc_sum[DELTA_W-1:0];
            end
        end
    end

    // Config may only change while idle and never to a zero divide ratio.
    always_comb begin
        cfg_ok    = cfg_we && (state_q == ST_IDLE) && (|cfg_in_div) && (|cfg_out_div);
        cfg_err_d = cfg_we && !cfg_ok;
        in_div_d  = in_div_q;
        out_div_d = out_div_q;
        delta_d   = delta_q;
        if (cfg_ok) begin
            in_div_d  = cfg_in_div;
            out_div_d = cfg_out_div;
            delta_d   = cfg_delta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fill_cnt_q <= '0;
            d_q        <= '0;
            cfg_err_q  <= 1'b0;
            in_div_q   <= DIV_W'(DEF_IN_DIV);
            out_div_q  <= DIV_W'(DEF_OUT_DIV);
            delta_q    <= DELTA_W'(DEF_DELTA);
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            d_q        <= d_d;
            cfg_err_q  <= cfg_err_d;
            in_div_q   <= in_div_d;
            out_div_q  <= out_div_d;
            delta_q    <= delta_d;
        end
    end

endmodule

// File: tb/tb_farrow_sched.sv
// Directed bench for farrow_sched: per-cycle expectation tables for whole runs,
// plus hand-written sequences for config rejection, stop, start/stop races and reset.
module tb_farrow_sched;

    logic       clk = 1'b0;
    logic       reset, start, stop, cfg_we;
    logic [3:0] cfg_in_div, cfg_out_div;
    logic [7:0] cfg_delta;
    logic       ena_in, ena_out, wrap, primed, busy, cfg_err;
    logic [8:0] d_out;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          scn;
        int          cyc;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[$];

    farrow_sched dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .cfg_we      (cfg_we),
        .cfg_in_div  (cfg_in_div),
        .cfg_out_div (cfg_out_div),
        .cfg_delta   (cfg_delta),
        .ena_in      (ena_in),
        .ena_out     (ena_out),
        .d_out       (d_out),
        .wrap        (wrap),
        .primed      (primed),
        .busy        (busy),
        .cfg_err     (cfg_err),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Packing order: {state, busy, primed, ena_in, ena_out, wrap, cfg_err, d_out}
    function automatic logic [16:0] pk(int st, int b, int p, int ei, int eo, int w, int ce, int d);
        return {2'(st), 1'(b), 1'(p), 1'(ei), 1'(eo), 1'(w), 1'(ce), 9'(d)};
    endfunction

    function automatic logic [16:0] act();
        return {state_o, busy, primed, ena_in, ena_out, wrap, cfg_err, d_out};
    endfunction

    task automatic chk(input string nm, input logic [16:0] a, input logic [16:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got st=%0d busy=%b primed=%b ei=%b eo=%b wrap=%b cerr=%b d=%0d, expected st=%0d busy=%b primed=%b ei=%b eo=%b wrap=%b cerr=%b d=%0d",
                     nm, a[16:15], a[14], a[13], a[12], a[11], a[10], a[9], a[8:0],
                     e[16:15], e[14], e[13], e[12], e[11], e[10], e[9], e[8:0]);
        end
    endtask

    task automatic addv(input int s, input int c, input logic [16:0] e);
        vecs.push_back('{s, c, e});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Pulses start in relative cycle 0 and checks every table row of the scenario.
    task automatic run_scn(input int scn, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            foreach (vecs[i]) begin
                if (vecs[i].scn == scn && vecs[i].cyc == c) begin
                    chk($sformatf("s%0d_c%0d", scn, c), act(), vecs[i].exp);
                end
            end
            start = (c == 0);
            cyc();
        end
        start = 1'b0;
    endtask

    initial begin
        // Scenario 1: default config 3/4/85
        addv(1,  0, pk(0, 0, 0, 0, 0, 0, 0,   0));
        addv(1,  1, pk(1, 1, 0, 0, 0, 0, 0,   0));
        addv(1,  3, pk(1, 1, 0, 1, 0, 0, 0,   0));
        addv(1, 12, pk(1, 1, 0, 1, 0, 0, 0,   0));
        addv(1, 13, pk(2, 1, 1, 0, 0, 0, 0,   0));
        addv(1, 15, pk(2, 1, 1, 1, 0, 0, 0,   0));
        addv(1, 16, pk(2, 1, 1, 0, 1, 0, 0,   0));
        addv(1, 20, pk(2, 1, 1, 0, 1, 0, 0,  85));
        addv(1, 21, pk(2, 1, 1, 1, 0, 0, 0, 170));
        addv(1, 24, pk(2, 1, 1, 1, 1, 0, 0, 170));
        addv(1, 28, pk(2, 1, 1, 0, 1, 1, 0, 255));
        addv(1, 29, pk(2, 1, 1, 0, 0, 0, 0,  84));
        // Scenario 2: config 1/2/128, d held at 84 from the previous run until start
        addv(2,  0, pk(0, 0, 0, 0, 0, 0, 0,  84));
        addv(2,  1, pk(1, 1, 0, 1, 0, 0, 0,   0));
        addv(2,  4, pk(1, 1, 0, 1, 0, 0, 0,   0));
        addv(2,  5, pk(2, 1, 1, 1, 0, 0, 0,   0));
        addv(2,  6, pk(2, 1, 1, 1, 1, 0, 0,   0));
        addv(2,  7, pk(2, 1, 1, 1, 0, 0, 0, 128));
        addv(2,  8, pk(2, 1, 1, 1, 1, 1, 0, 128));
        addv(2,  9, pk(2, 1, 1, 1, 0, 0, 0,   0));
        addv(2, 10, pk(2, 1, 1, 1, 1, 0, 0,   0));
        // Scenario 3: config must still be 1/2/128 after a rejected write
        addv(3,  0, pk(0, 0, 0, 0, 0, 0, 0, 128));
        addv(3,  1, pk(1, 1, 0, 1, 0, 0, 0,   0));
        addv(3,  5, pk(2, 1, 1, 1, 0, 0, 0,   0));
        addv(3,  6, pk(2, 1, 1, 1, 1, 0, 0,   0));
        addv(3,  8, pk(2, 1, 1, 1, 1, 1, 0, 128));
        // Scenario 4: default config, aborted in FILL
        addv(4,  0, pk(0, 0, 0, 0, 0, 0, 0,   0));
        addv(4,  3, pk(1, 1, 0, 1, 0, 0, 0,   0));

        reset = 1'b1; start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
        cfg_in_div = 4'd0; cfg_out_div = 4'd0; cfg_delta = 8'd0;
        cyc();
        cyc();
        reset = 1'b0;

        // Nominal run, then stop from RUN
        run_scn(1, 30);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_from_run", act(), pk(0, 0, 0, 0, 0, 0, 0, 84));

        // Accepted config write in IDLE
        cfg_we = 1'b1; cfg_in_div = 4'd1; cfg_out_div = 4'd2; cfg_delta = 8'd128;
        cyc();
        cfg_we = 1'b0;
        run_scn(2, 12);

        // Rejected write during RUN: error pulse, cadence unchanged
        cfg_we = 1'b1; cfg_in_div = 4'd5; cfg_out_div = 4'd5; cfg_delta = 8'd3;
        cyc();
        cfg_we = 1'b0;
        chk("run_wr_err",   act(), pk(2, 1, 1, 1, 0, 0, 1,   0));
        cyc();
        chk("run_wr_after", act(), pk(2, 1, 1, 1, 1, 0, 0,   0));
        cyc();
        chk("run_wr_next",  act(), pk(2, 1, 1, 1, 0, 0, 0, 128));
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_idle_d",  act(), pk(0, 0, 0, 0, 0, 0, 0, 128));

        // Rejected write in IDLE with out_div=0
        cfg_we = 1'b1; cfg_in_div = 4'd7; cfg_out_div = 4'd0; cfg_delta = 8'd9;
        cyc();
        cfg_we = 1'b0;
        chk("zero_div_err",   act(), pk(0, 0, 0, 0, 0, 0, 1, 128));
        cyc();
        chk("zero_div_clear", act(), pk(0, 0, 0, 0, 0, 0, 0, 128));
        run_scn(3, 9);

        // Reset asserted in RUN
        reset = 1'b1;
        cyc();
        chk("reset_in_run", act(), pk(0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;

        // Stop after the second ena_in of FILL, then a full restart
        run_scn(4, 6);
        chk("fill_2nd_ein", act(), pk(1, 1, 0, 1, 0, 0, 0, 0));
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_in_fill", act(), pk(0, 0, 0, 0, 0, 0, 0, 0));
        cyc();
        run_scn(1, 30);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("restart_stop", act(), pk(0, 0, 0, 0, 0, 0, 0, 84));

        // start and stop together in IDLE: stop wins
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        chk("start_stop_same", act(), pk(0, 0, 0, 0, 0, 0, 0, 84));
        cyc();
        chk("start_stop_hold", act(), pk(0, 0, 0, 0, 0, 0, 0, 84));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
